// File: rtl/channel_capture_scheduler.sv
// Capture/drain sequencer for the per-channel sample shift buffers.
// A prescaled tick launches a round-robin write sweep over all channels.
// Between sweeps, a host drain request empties one channel. Fill levels
// are tracked here; the buffer array itself lives outside this block.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a sample tick (priority) or a host drain request
// S_SWEEP | one cycle per channel index, write strobe for enabled ones
// S_DRAIN | one read strobe per stored sample of rd_sel
// S_DONE  | drain complete pulse; fill of rd_sel cleared
module channel_capture_scheduler #(
   parameter int NUM_CHANNELS = 14,
   parameter int DEPTH        = 10,
   parameter int TICK_DIV     = 100,
   localparam int CH_W        = $clog2(NUM_CHANNELS),
   localparam int FILL_W      = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NUM_CHANNELS-1:0] chan_mask,
   output logic                    wr_en,
   output logic [CH_W-1:0]         wr_chan,
   input  logic                    rd_req,
   input  logic [CH_W-1:0]         rd_chan,
   output logic                    rd_ack,
   output logic                    rd_en,
   output logic [CH_W-1:0]         rd_sel,
   output logic                    rd_done,
   output logic [NUM_CHANNELS-1:0] full,
   output logic                    overrun
);

   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(TICK_DIV - 1);
   localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CHANNELS - 1);
   localparam logic [CH_W:0]     NUM_CH_EXT = (CH_W + 1)'(NUM_CHANNELS);
   localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic [PRE_W-1:0]  pre_cnt;
   logic              tick;
   logic [CH_W-1:0]   idx, idx_nx, idx_inc;
   logic              wr_en_nx;
   logic [CH_W-1:0]   wr_chan_nx;
   logic [CH_W-1:0]   rd_sel_nx;
   logic [FILL_W-1:0] drain_cnt, drain_cnt_nx;
   logic [FILL_W-1:0] req_fill;
   logic [FILL_W-1:0] fill [NUM_CHANNELS];

   assign idx_inc = idx + CH_W'(1);

   // Prescaler: tick is a registered pulse in the cycle the count has wrapped to 0
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= enable && (pre_cnt == PRE_MAX);
         if (enable) begin
            pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PRE_W'(1);
         end
      end
   end

   // Fill level of the requested channel; out-of-range channels drain as empty
   always_comb begin
      req_fill = '0;
      if ({1'b0, rd_chan} < NUM_CH_EXT) begin
         req_fill = fill[rd_chan];
      end
   end

   // Next-state logic; sweep strobes are computed one cycle ahead and registered
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      wr_en_nx     = 1'b0;
      wr_chan_nx   = '0;
      rd_sel_nx    = rd_sel;
      drain_cnt_nx = drain_cnt;
      rd_ack       = 1'b0;
      rd_en        = 1'b0;
      rd_done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) begin
               state_nx   = S_SWEEP;
               idx_nx     = '0;
               wr_en_nx   = chan_mask[0];
               wr_chan_nx = '0;
            end else if (rd_req && !reset) begin
               rd_ack       = 1'b1;
               rd_sel_nx    = rd_chan;
               drain_cnt_nx = req_fill;
               state_nx     = (req_fill == '0) ? S_DONE : S_DRAIN;
            end
         end
         S_SWEEP: begin
            if (idx == LAST_CH) begin
               state_nx = S_IDLE;
            end else begin
               idx_nx     = idx_inc;
               wr_en_nx   = chan_mask[idx_inc];
               wr_chan_nx = idx_inc;
            end
         end
         S_DRAIN: begin
            rd_en        = 1'b1;
            drain_cnt_nx = drain_cnt - FILL_ONE;
            if (drain_cnt == FILL_ONE) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            rd_done  = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State and registered control outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         wr_en     <= 1'b0;
         wr_chan   <= '0;
         rd_sel    <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         wr_en     <= wr_en_nx;
         wr_chan   <= wr_chan_nx;
         rd_sel    <= rd_sel_nx;
         drain_cnt <= drain_cnt_nx;
      end
   end

   // Sticky overrun: a tick outside IDLE is dropped, the prescaler is not disturbed
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (tick && (state != S_IDLE)) begin
         overrun <= 1'b1;
      end
   end

   // Fill counters saturate at DEPTH (buffer drops its oldest sample when full)
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (reset) begin
            fill[i] <= '0;
         end else if ((state == S_DONE) && (rd_sel == CH_W'(i))) begin
            fill[i] <= '0;
         end else if (wr_en && (wr_chan == CH_W'(i)) && (fill[i] != FILL_MAX)) begin
            fill[i] <= fill[i] + FILL_ONE;
         end
      end
   end

   // Full flags straight from the counters
   always_comb begin
      full = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         full[i] = (fill[i] == FILL_MAX);
      end
   end

endmodule
